// File: rtl/hyperbus_pkg.sv
// Shared definitions for the HyperBus burst controller: the one-hot state
// encoding, command/address (CA) field positions, RWDS patterns and a
// counter-width helper.
package hyperbus_pkg;

  // One-hot state encoding; any other value is treated as unreachable.
  typedef enum logic [7:0] {
    ST_RESET   = 8'b0000_0001,
    ST_IDLE    = 8'b0000_0010,
    ST_CMD     = 8'b0000_0100,
    ST_LATENCY = 8'b0000_1000,
    ST_WRITE   = 8'b0001_0000,
    ST_READ    = 8'b0010_0000,
    ST_RECOVER = 8'b0100_0000,
    ST_ERROR   = 8'b1000_0000
  } state_t;

  // 48-bit CA word layout.
  localparam int CA_W         = 48;
  localparam int CA_RW_BIT    = 47;
  localparam int CA_AS_BIT    = 46;
  localparam int CA_BURST_BIT = 45;
  localparam int CA_ADR_HI    = 44;
  localparam int CA_ADR_LO    = 16;

  // RWDS patterns: read strobe, and the latency-doubling indication in CMD.
  localparam logic [1:0] RWDS_STROBE = 2'b01;
  localparam logic [1:0] RWDS_LAT2X  = 2'b11;

  localparam int CMD_CYCLES     = 3;
  localparam int RECOVER_CYCLES = 2;

  // Bits needed to hold values 0..maxval.
  function automatic int cnt_width(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/hyperbus_ca_shift.sv
// Packs the command/address fields into the 48-bit CA word and shifts it out
// 16 bits per cycle during the command phase.
module hyperbus_ca_shift
  import hyperbus_pkg::*;
(
  input  logic        clk,
  input  logic        load,
  input  logic        shift,
  input  logic        we,
  input  logic        reg_space,
  input  logic [31:0] adr,
  output logic [15:0] ca_word
);

  logic [CA_W-1:0] ca;
  logic [CA_W-1:0] ca_packed;

  // CA field packing: read/write, address space, linear burst, word address.
  always_comb begin
    ca_packed                       = '0;
    ca_packed[CA_RW_BIT]            = ~we;
    ca_packed[CA_AS_BIT]            = reg_space;
    ca_packed[CA_BURST_BIT]         = 1'b1;
    ca_packed[CA_ADR_HI:CA_ADR_LO]  = adr[31:3];
    ca_packed[2:0]                  = adr[2:0];
  end

  // Load on command accept, then move the next 16 bits to the top each cycle.
  always_ff @(posedge clk) begin
    if (load) begin
      ca <= ca_packed;
    end else if (shift) begin
      ca <= {ca[CA_W-17:0], 16'h0000};
    end
  end

  assign ca_word = ca[CA_W-1 -: 16];

endmodule

// File: rtl/hyperbus_burst_ctrl.sv
// HyperBus primary controller with linear multi-word bursts, valid/ready
// command and write-data interfaces, per-word read timeout and a clearable
// error state. Define HYPERBUS_WMASK_EN to drive the write byte mask on RWDS;
// without it RWDS is driven low during writes and every byte is written.
module hyperbus_burst_ctrl
  import hyperbus_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int TACC_COUNT    = 5,
  parameter int RESET_COUNT   = 2,
  parameter int MAX_BURST     = 16,
  parameter int TIMEOUT       = 15,
  parameter int FIXED_LATENCY = 0,
  localparam int LW           = $clog2(MAX_BURST + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic               cmd_reg,
  input  logic [31:0]        cmd_adr,
  input  logic [LW-1:0]      cmd_len,
  input  logic               wdat_valid,
  output logic               wdat_ready,
  input  logic [2*WIDTH-1:0] wdat,
  input  logic [1:0]         wmask,
  output logic               rdat_valid,
  output logic [2*WIDTH-1:0] rdat,
  output logic               rdat_last,
  output logic               busy,
  output logic               error_o,
  input  logic               err_clr,
  output logic               hbus_rstn,
  output logic               hbus_csn,
  output logic               hbus_ck_en,
  output logic [2*WIDTH-1:0] dq_o,
  output logic               dq_oe,
  input  logic [2*WIDTH-1:0] dq_i,
  output logic [1:0]         rwds_o,
  output logic               rwds_oe,
  input  logic [1:0]         rwds_i
);

  localparam int DW      = 2 * WIDTH;
  localparam int LAT_MAX = 2 * TACC_COUNT;
  localparam int CNT_MAX = (LAT_MAX > RESET_COUNT) ?
                           ((LAT_MAX > CMD_CYCLES) ? LAT_MAX : CMD_CYCLES) :
                           ((RESET_COUNT > CMD_CYCLES) ? RESET_COUNT : CMD_CYCLES);
  localparam int CW      = cnt_width(CNT_MAX);
  localparam int TW      = cnt_width(TIMEOUT);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [LW-1:0] words;
  logic [TW-1:0] tmo;
  logic          is_write;
  logic [LW-1:0] len_eff;
  logic          lat2x;
  logic          strobe;
  logic          cmd_fire;
  logic [15:0]   ca_word;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign strobe   = (rwds_i == RWDS_STROBE);
  assign lat2x    = (FIXED_LATENCY != 0) || (rwds_i == RWDS_LAT2X);

  // Zero-length commands move one word; oversize lengths clamp to MAX_BURST.
  always_comb begin
    if (cmd_len == '0) begin
      len_eff = LW'(1);
    end else if (cmd_len > LW'(MAX_BURST)) begin
      len_eff = LW'(MAX_BURST);
    end else begin
      len_eff = cmd_len;
    end
  end

  hyperbus_ca_shift u_ca (
    .clk       (clk),
    .load      (cmd_fire),
    .shift     (state == ST_CMD),
    .we        (cmd_we),
    .reg_space (cmd_reg),
    .adr       (cmd_adr),
    .ca_word   (ca_word)
  );

  // Main FSM with phase counter, word counter, read timeout and read capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RESET;
      cnt        <= CW'(RESET_COUNT);
      words      <= '0;
      tmo        <= '0;
      is_write   <= 1'b0;
      rdat_valid <= 1'b0;
      rdat_last  <= 1'b0;
      rdat       <= '0;
    end else begin
      rdat_valid <= 1'b0;
      rdat_last  <= 1'b0;
      case (state)
        ST_RESET: begin
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - CW'(1);
        end
        ST_IDLE: begin
          if (cmd_fire) begin
            state    <= ST_CMD;
            cnt      <= '0;
            is_write <= cmd_we;
            words    <= len_eff;
          end
        end
        ST_CMD: begin
          if (cnt == CW'(CMD_CYCLES - 1)) begin
            state <= ST_LATENCY;
            cnt   <= lat2x ? CW'(2 * TACC_COUNT - 1) : CW'(TACC_COUNT - 1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_LATENCY: begin
          if (cnt == '0) begin
            state <= is_write ? ST_WRITE : ST_READ;
            tmo   <= TW'(TIMEOUT);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_WRITE: begin
          if (wdat_valid) begin
            words <= words - LW'(1);
            if (words <= LW'(1)) begin
              state <= ST_RECOVER;
              cnt   <= CW'(RECOVER_CYCLES - 1);
            end
          end
        end
        ST_READ: begin
          // A strobe in the same cycle the timeout expires still counts.
          if (strobe) begin
            rdat       <= dq_i;
            rdat_valid <= 1'b1;
            tmo        <= TW'(TIMEOUT);
            words      <= words - LW'(1);
            if (words <= LW'(1)) begin
              rdat_last <= 1'b1;
              state     <= ST_RECOVER;
              cnt       <= CW'(RECOVER_CYCLES - 1);
            end
          end else if (tmo == '0) begin
            state <= ST_ERROR;
          end else begin
            tmo <= tmo - TW'(1);
          end
        end
        ST_RECOVER: begin
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - CW'(1);
        end
        ST_ERROR: begin
          if (err_clr) begin
            state <= ST_RECOVER;
            cnt   <= CW'(RECOVER_CYCLES - 1);
          end
        end
        default: begin
          state <= ST_RESET;
          cnt   <= CW'(RESET_COUNT);
        end
      endcase
    end
  end

  // Pad and handshake controls are decoded straight from the one-hot state
  // register, so an asynchronous reset forces them to idle values at once.
  assign cmd_ready  = (state == ST_IDLE);
  assign wdat_ready = (state == ST_WRITE);
  assign busy       = (state != ST_IDLE);
  assign error_o    = (state == ST_ERROR);
  assign hbus_rstn  = (state != ST_RESET);
  assign hbus_csn   = !(state inside {ST_CMD, ST_LATENCY, ST_WRITE, ST_READ});
  assign hbus_ck_en = (state inside {ST_CMD, ST_LATENCY, ST_READ}) ||
                      ((state == ST_WRITE) && wdat_valid);
  assign dq_oe      = (state inside {ST_CMD, ST_WRITE});
  assign rwds_oe    = (state == ST_WRITE);

  // DQ output mux: CA word during command, write data during write.
  always_comb begin
    dq_o = '0;
    if (state == ST_CMD) begin
      dq_o = DW'(ca_word);
    end else if (state == ST_WRITE) begin
      dq_o = wdat;
    end
  end

`ifdef HYPERBUS_WMASK_EN
  assign rwds_o = (state == ST_WRITE) ? wmask : 2'b00;
`else
  logic unused_wmask;
  assign unused_wmask = ^wmask;
  assign rwds_o       = 2'b00;
`endif

endmodule

// File: tb/tb_hyperbus_burst_ctrl.sv
// Self-checking bench for hyperbus_burst_ctrl: directed scenarios plus
// randomized read/write bursts checked against a transaction-level model.
`timescale 1ns/1ps
module tb_hyperbus_burst_ctrl;

  localparam int WIDTH = 8;
  localparam int TACC  = 5;
  localparam int RSTC  = 2;
  localparam int MAXB  = 16;
  localparam int TMO   = 15;
  localparam int LW    = $clog2(MAXB + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_we, cmd_reg;
  logic [31:0]   cmd_adr;
  logic [LW-1:0] cmd_len;
  logic          wdat_valid, wdat_ready;
  logic [15:0]   wdat;
  logic [1:0]    wmask;
  logic          rdat_valid, rdat_last;
  logic [15:0]   rdat;
  logic          busy, error_o, err_clr;
  logic          hbus_rstn, hbus_csn, hbus_ck_en;
  logic [15:0]   dq_o, dq_i;
  logic          dq_oe;
  logic [1:0]    rwds_o, rwds_i;
  logic          rwds_oe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hyperbus_burst_ctrl #(
    .WIDTH(WIDTH), .TACC_COUNT(TACC), .RESET_COUNT(RSTC), .MAX_BURST(MAXB),
    .TIMEOUT(TMO), .FIXED_LATENCY(0)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_reg(cmd_reg), .cmd_adr(cmd_adr), .cmd_len(cmd_len),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat), .wmask(wmask),
    .rdat_valid(rdat_valid), .rdat(rdat), .rdat_last(rdat_last),
    .busy(busy), .error_o(error_o), .err_clr(err_clr),
    .hbus_rstn(hbus_rstn), .hbus_csn(hbus_csn), .hbus_ck_en(hbus_ck_en),
    .dq_o(dq_o), .dq_oe(dq_oe), .dq_i(dq_i),
    .rwds_o(rwds_o), .rwds_oe(rwds_oe), .rwds_i(rwds_i)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: CA word built arithmetically from the field rules.
  function automatic logic [47:0] model_ca(input logic we, input logic rg, input logic [31:0] adr);
    logic [47:0] ca;
    ca = (48'(!we) << 47) + (48'(rg) << 46) + (48'(1) << 45)
       + (48'(adr >> 3) << 16) + 48'(adr % 8);
    return ca;
  endfunction

  function automatic int model_len(input int len);
    if (len == 0) return 1;
    if (len > MAXB) return MAXB;
    return len;
  endfunction

  function automatic int model_lat(input logic [1:0] rw);
    return (rw == 2'b11) ? 2 * TACC : TACC;
  endfunction

  function automatic logic [1:0] model_rwds(input logic [1:0] m);
`ifdef HYPERBUS_WMASK_EN
    return m;
`else
    return 2'b00 & m;
`endif
  endfunction

  // Issues one command; returns in the first latency cycle (3 cycles after CMD entry).
  task automatic start_cmd(input logic we, input logic rg, input logic [31:0] adr,
                           input int len, input logic [1:0] rw);
    logic [47:0] ca;
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    ca = model_ca(we, rg, adr);
    cmd_valid = 1'b1; cmd_we = we; cmd_reg = rg; cmd_adr = adr;
    cmd_len = LW'(len); rwds_i = rw;
    tick();
    cmd_valid = 1'b0;
    chk("cmd_ck_en", hbus_ck_en, 1);
    chk("cmd_csn", hbus_csn, 0);
    chk("cmd_dq_oe", dq_oe, 1);
    chk("ca_word0", dq_o, ca[47:32]);
    tick();
    chk("ca_word1", dq_o, ca[31:16]);
    tick();
    chk("ca_word2", dq_o, ca[15:0]);
    tick();
    rwds_i = 2'b00;
    chk("lat_dq_oe", dq_oe, 0);
    chk("lat_csn", hbus_csn, 0);
  endtask

  task automatic finish_recover(input string tag);
    chk({tag, "_csn_rec"}, hbus_csn, 1);
    tick();
    chk({tag, "_rec2"}, cmd_ready, 0);
    tick();
    chk({tag, "_idle"}, cmd_ready, 1);
  endtask

  // first_gap < 0 picks a random gap; otherwise the first strobe comes that many cycles into READ.
  task automatic do_read(input logic [31:0] adr, input int len, input logic [1:0] rw,
                         input int first_gap, input bit directed);
    int nw, lat, gap;
    logic [15:0] d;
    nw  = model_len(len);
    lat = model_lat(rw);
    start_cmd(1'b0, 1'b0, adr, len, rw);
    repeat (lat) tick();
    chk("rd_rwds_oe", rwds_oe, 0);
    for (int i = 0; i < nw; i++) begin
      gap = (i == 0 && first_gap >= 0) ? first_gap : int'($urandom_range(0, 3));
      repeat (gap) tick();
      if (gap > 0) chk("rd_valid_gap", rdat_valid, 0);
      d = directed ? 16'(16'hA001 + i) : 16'($urandom);
      rwds_i = 2'b01; dq_i = d;
      tick();
      rwds_i = 2'b00; dq_i = '0;
      chk("rd_valid", rdat_valid, 1);
      chk("rd_data", rdat, d);
      chk("rd_last", rdat_last, (i == nw - 1) ? 1 : 0);
      chk("rd_no_err", error_o, 0);
    end
    finish_recover("rd");
    chk("rd_valid_end", rdat_valid, 0);
  endtask

  task automatic do_write(input logic [31:0] adr, input int len, input logic [1:0] rw,
                          input int stall_at, input int stall_len, input bit directed);
    int nw, lat, n;
    logic [15:0] d;
    logic [1:0] m;
    nw  = model_len(len);
    lat = model_lat(rw);
    start_cmd(1'b1, 1'b0, adr, len, rw);
    n = 3;
    while (!wdat_ready && n < 60) begin tick(); n++; end
    chk("wr_latency", n, 3 + lat);
    for (int i = 0; i < nw; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          wdat_valid = 1'b0;
          #1;
          chk("stall_ck_en", hbus_ck_en, 0);
          chk("stall_csn", hbus_csn, 0);
          chk("stall_dq_oe", dq_oe, 1);
          tick();
        end
      end
      d = directed ? ((i == 0) ? 16'h1234 : 16'h5678) : 16'($urandom);
      m = directed ? ((i == 1) ? 2'b10 : 2'b00) : 2'($urandom_range(0, 3));
      wdat_valid = 1'b1; wdat = d; wmask = m;
      #1;
      chk("wr_ready", wdat_ready, 1);
      chk("wr_dq", dq_o, d);
      chk("wr_rwds", rwds_o, model_rwds(m));
      chk("wr_oe", {dq_oe, rwds_oe}, 2'b11);
      chk("wr_ck_en", hbus_ck_en, 1);
      tick();
    end
    wdat_valid = 1'b0;
    chk("wr_done_ready", wdat_ready, 0);
    finish_recover("wr");
  endtask

  initial begin
    int n;
    logic [1:0] rw;
    rst = 1'b1; cmd_valid = 0; cmd_we = 0; cmd_reg = 0; cmd_adr = '0; cmd_len = '0;
    wdat_valid = 0; wdat = '0; wmask = '0; err_clr = 0; dq_i = '0; rwds_i = '0;
    tick(); tick();
    chk("rst_rstn", hbus_rstn, 0);
    chk("rst_csn", hbus_csn, 1);
    chk("rst_ck_en", hbus_ck_en, 0);
    chk("rst_oe", {dq_oe, rwds_oe}, 2'b00);
    chk("rst_ready", {cmd_ready, wdat_ready}, 2'b00);
    chk("rst_rd", {rdat_valid, rdat_last, error_o}, 3'b000);
    chk("rst_busy", busy, 1);
    chk("rst_rdat", rdat, 0);
    rst = 1'b0;
    n = 0;
    while (!hbus_rstn && n < 20) begin n++; tick(); end
    chk("rstn_low_cycles", n, RSTC + 1);
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_csn", hbus_csn, 1);

    // err_clr outside ERROR has no effect.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("errclr_idle_ready", cmd_ready, 1);
    chk("errclr_idle_busy", busy, 0);

    // Directed read, 1x latency: first strobe right at READ entry.
    do_read(32'h0000_0100, 4, 2'b00, 0, 1'b1);
    // Directed write, 2x latency, masked second word.
    do_write(32'h0000_0040, 2, 2'b11, -1, 0, 1'b1);
    // Write stall of 3 cycles mid-burst.
    do_write(32'h0000_1000, 4, 2'b00, 2, 3, 1'b0);
    // Strobe arriving exactly as the timeout expires is accepted.
    do_read(32'h0000_2008, 3, 2'b11, TMO, 1'b0);

    // Read timeout: no strobes at all.
    start_cmd(1'b0, 1'b0, 32'h0000_0200, 2, 2'b00);
    repeat (model_lat(2'b00) + TMO) tick();
    chk("tmo_not_yet", error_o, 0);
    tick();
    chk("tmo_error", error_o, 1);
    chk("tmo_csn", hbus_csn, 1);
    chk("tmo_busy", busy, 1);
    cmd_valid = 1'b1;
    tick(); tick();
    chk("err_held", error_o, 1);
    chk("err_cmd_ignored", cmd_ready, 0);
    chk("err_no_rdat", rdat_valid, 0);
    cmd_valid = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("errclr_leaves", error_o, 0);
    finish_recover("errclr");

    // Zero-length commands move one word.
    do_write(32'h0000_0300, 0, 2'b00, -1, 0, 1'b0);
    do_read(32'h0000_0308, 0, 2'b00, -1, 1'b0);

    // Randomized bursts.
    for (int t = 0; t < 10; t++) begin
      rw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(32'($urandom), int'($urandom_range(0, 20)), rw,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
      else
        do_read(32'($urandom), int'($urandom_range(0, 20)), rw,
                ($urandom_range(0, 3) == 0) ? TMO : -1, 1'b0);
    end

    // Asynchronous reset in the middle of a write burst.
    start_cmd(1'b1, 1'b0, 32'h0000_0400, 3, 2'b00);
    n = 3;
    while (!wdat_ready && n < 60) begin tick(); n++; end
    chk("ar_wr_latency", n, 3 + TACC);
    wdat_valid = 1'b1; wdat = 16'hBEEF; wmask = 2'b00;
    tick();
    rst = 1'b1;
    #1;
    chk("ar_rstn", hbus_rstn, 0);
    chk("ar_csn", hbus_csn, 1);
    chk("ar_ck_en", hbus_ck_en, 0);
    chk("ar_oe", {dq_oe, rwds_oe}, 2'b00);
    chk("ar_ready", {cmd_ready, wdat_ready}, 2'b00);
    chk("ar_rd", {rdat_valid, rdat_last, error_o}, 3'b000);
    chk("ar_busy", busy, 1);
    chk("ar_rdat", rdat, 0);
    wdat_valid = 1'b0;
    tick();
    rst = 1'b0;
    n = 0;
    while (!cmd_ready && n < 20) begin n++; tick(); end
    chk("ar_back_idle", cmd_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
